// File: rtl/load_bram_row_writer.sv
// Write side of the disparity row-buffer BRAM: raster stream in, circular row buffer out.
// Optional stall cycle counter output enabled by defining LOAD_BRAM_STALL_CNT_EN.
module load_bram_row_writer #(
  parameter int NUM_OF_ROWS_IN_BRAM = 8,
  parameter int VRES                = 480,
  parameter int HRES                = 640,
  parameter int BRAM_DATA_WIDTH     = 16,
  parameter int BRAM_ADDR_WIDTH     = 13,
  parameter int BRAM_WE_WIDTH       = 1,
  parameter int window              = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic                       pix_sof,
  input  logic [BRAM_DATA_WIDTH-1:0] pix_data,
  output logic                       en,
  output logic [BRAM_WE_WIDTH-1:0]   we,
  output logic [BRAM_ADDR_WIDTH-1:0] addr,
  output logic [BRAM_DATA_WIDTH-1:0] din,
  input  logic                       finished_row,
  output logic                       busy,
  output logic                       go,
  output logic                       sof_err
`ifdef LOAD_BRAM_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);
  localparam int WIN_HALF    = window / 2;
  localparam int RW          = $clog2(VRES + 1);
  localparam int CW          = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int SW          = (NUM_OF_ROWS_IN_BRAM > 1) ? $clog2(NUM_OF_ROWS_IN_BRAM) : 1;
  localparam int LAST_CENTRE = VRES - 1 - WIN_HALF;

  typedef enum logic [1:0] {LOAD, HOLD, FRAME_END} state_t;

  state_t                     state_q, state_d;
  logic [RW-1:0]              wr_row_q, wr_row_d;
  logic [RW-1:0]              centre_q, centre_d;
  logic [RW-1:0]              rows_done_q, rows_done_d;
  logic [CW-1:0]              wr_col_q, wr_col_d;
  logic [SW-1:0]              wr_slot_q, wr_slot_d;
  logic                       row_end_q, row_end_d;
  logic                       en_q, en_d;
  logic [BRAM_WE_WIDTH-1:0]   we_q, we_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BRAM_DATA_WIDTH-1:0] din_q, din_d;
  logic                       sof_err_q, sof_err_d;
  logic                       xfer, fin_ok;
  int                         row_i, base_i;

  assign pix_ready = (state_q == LOAD);
  assign busy      = (int'(rows_done_q) < int'(centre_q) + WIN_HALF + 1) |
                     ((state_q != FRAME_END) & (rows_done_q == '0));
  assign go        = ~busy;
  assign en        = en_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign sof_err   = sof_err_q;

  always_comb begin
    xfer        = pix_valid & pix_ready;
    fin_ok      = finished_row & ~busy;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_slot_d   = wr_slot_q;
    centre_d    = centre_q;
    rows_done_d = rows_done_q;
    row_end_d   = xfer & (int'(wr_col_q) == HRES - 1);
    en_d        = xfer;
    we_d        = {BRAM_WE_WIDTH{xfer}};
    addr_d      = addr_q;
    din_d       = din_q;
    sof_err_d   = 1'b0;

    if (xfer) begin
      addr_d    = BRAM_ADDR_WIDTH'(int'(wr_slot_q) * HRES + int'(wr_col_q));
      din_d     = pix_data;
      // sof must coincide exactly with position (0,0)
      sof_err_d = pix_sof ^ ((wr_row_q == '0) & (wr_col_q == '0));
      if (row_end_d) begin
        wr_col_d  = '0;
        wr_row_d  = wr_row_q + 1'b1;
        wr_slot_d = (int'(wr_slot_q) == NUM_OF_ROWS_IN_BRAM - 1) ? '0 : wr_slot_q + 1'b1;
      end else begin
        wr_col_d  = wr_col_q + 1'b1;
      end
    end

    // a row counts as resident one cycle after its last word hits the BRAM port
    if (row_end_q) rows_done_d = rows_done_q + 1'b1;

    if (fin_ok) begin
      if (int'(centre_q) == LAST_CENTRE) begin
        centre_d    = RW'(WIN_HALF);
        wr_row_d    = '0;
        wr_col_d    = '0;
        wr_slot_d   = '0;
        rows_done_d = '0;
        row_end_d   = 1'b0;
      end else begin
        centre_d    = centre_q + 1'b1;
      end
    end

    row_i  = int'(wr_row_d);
    base_i = int'(centre_d) - WIN_HALF;
    if (row_i >= VRES)                               state_d = FRAME_END;
    else if (row_i - base_i >= NUM_OF_ROWS_IN_BRAM)  state_d = HOLD;
    else                                             state_d = LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_slot_q   <= '0;
      centre_q    <= RW'(WIN_HALF);
      rows_done_q <= '0;
      row_end_q   <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_slot_q   <= wr_slot_d;
      centre_q    <= centre_d;
      rows_done_q <= rows_done_d;
      row_end_q   <= row_end_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      sof_err_q   <= sof_err_d;
    end
  end

`ifdef LOAD_BRAM_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // initial fill (rows_done == 0) is not a stall
  always_comb begin
    stall_d = stall_q;
    if (busy && (rows_done_q != '0) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_load_bram_row_writer.sv
// Randomized bench for load_bram_row_writer against a pixel-count reference model.
module tb_load_bram_row_writer;
  localparam int HRES = 16, VRES = 16, NROWS = 8, WIN = 3, WH = WIN / 2;
  localparam int DW = 16, AW = 13, WEW = 1;

  logic clk = 1'b0;
  logic reset, pix_valid, pix_sof, finished_row;
  logic [DW-1:0] pix_data;
  logic pix_ready, en, busy, go, sof_err;
  logic [WEW-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
`ifdef LOAD_BRAM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  load_bram_row_writer #(
    .NUM_OF_ROWS_IN_BRAM(NROWS), .VRES(VRES), .HRES(HRES), .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW), .BRAM_WE_WIDTH(WEW), .window(WIN)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_data(pix_data), .en(en), .we(we), .addr(addr), .din(din),
    .finished_row(finished_row), .busy(busy), .go(go), .sof_err(sof_err)
`ifdef LOAD_BRAM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0, n_err = 0;
  int dut_writes = 0;

  // model: pixels accepted this frame, centre row, resident rows, pending row completion
  int m_cnt, m_centre, m_done, m_pend, m_stall;
  logic m_en, m_sof;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    int row;
    row = m_cnt / HRES;
    return (row < VRES) && (row - (m_centre - WH) < NROWS);
  endfunction

  function automatic bit m_busy();
    return (m_done < m_centre + WH + 1) || ((m_cnt / HRES < VRES) && m_done == 0);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_centre = WH; m_done = 0; m_pend = 0; m_stall = 0;
    m_en = 1'b0; m_sof = 1'b0; m_addr = '0; m_din = '0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [DW-1:0] d, input bit f);
    bit xf, fn;
    xf = v && m_ready();
    fn = f && !m_busy();
    if (m_busy() && m_done > 0) m_stall++;
    m_en = xf;
    m_sof = 1'b0;
    m_done += m_pend;
    m_pend = 0;
    if (xf) begin
      m_addr = AW'(((m_cnt / HRES) % NROWS) * HRES + (m_cnt % HRES));
      m_din  = d;
      m_sof  = s != (m_cnt == 0);
      m_pend = (m_cnt % HRES == HRES - 1) ? 1 : 0;
      m_cnt++;
    end
    if (fn) begin
      if (m_centre == VRES - 1 - WH) begin
        m_centre = WH; m_cnt = 0; m_done = 0; m_pend = 0;
      end else begin
        m_centre++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("pix_ready", {31'd0, pix_ready}, {31'd0, m_ready()});
    chk("busy", {31'd0, busy}, {31'd0, m_busy()});
    chk("go", {31'd0, go}, {31'd0, !m_busy()});
    chk("en", {31'd0, en}, {31'd0, m_en});
    chk("we", {{(32-WEW){1'b0}}, we}, {{(32-WEW){1'b0}}, {WEW{m_en}}});
    chk("addr", {{(32-AW){1'b0}}, addr}, {{(32-AW){1'b0}}, m_addr});
    chk("din", {16'd0, din}, {16'd0, m_din});
    chk("sof_err", {31'd0, sof_err}, {31'd0, m_sof});
`ifdef LOAD_BRAM_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    if (en === 1'b1) dut_writes++;
  endtask

  task automatic cycle(input bit v, input bit s, input logic [DW-1:0] d, input bit f, input bit r);
    @(negedge clk);
    check_outputs();
    pix_valid = v; pix_sof = s; pix_data = d; finished_row = f; reset = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(v, s, d, f);
  endtask

  initial begin
    int vp, fp;
    bit s;
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; finished_row = 1'b0;
    model_reset();
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 1);

    // continuous fill from reset with no calculator progress: must stop at the slot limit
    dut_writes = 0;
    for (int i = 0; i < 200; i++) cycle(1, m_cnt == 0, DW'($urandom), 0, 0);
    @(negedge clk);
    chk("fill_writes", dut_writes, NROWS * HRES);
    chk("fill_last_addr", {{(32-AW){1'b0}}, addr}, 32'd127);
    chk("fill_hold_ready", {31'd0, pix_ready}, 32'd0);

    // one finished_row releases exactly one slot
    cycle(1, 0, DW'($urandom), 1, 0);
    for (int i = 0; i < 40; i++) cycle(1, 0, DW'($urandom), 0, 0);

    // randomized traffic with varying valid/finished densities, sof faults and a mid-run reset
    for (int blk = 0; blk < 10; blk++) begin
      vp = $urandom_range(40, 100);
      fp = $urandom_range(5, 60);
      for (int i = 0; i < 400; i++) begin
        s = (m_cnt == 0);
        if ($urandom_range(0, 19) == 0) s = !s;
        cycle($urandom_range(1, 100) <= vp, s, DW'($urandom), $urandom_range(1, 100) <= fp,
              (blk == 6 && i == 123));
      end
    end

    // reset mid-row: next pixel must land at address 0
    for (int i = 0; i < 5; i++) cycle(1, m_cnt == 0, DW'($urandom), 0, 0);
    cycle(0, 0, '0, 0, 1);
    cycle(1, 1, 16'hBEEF, 0, 0);
    @(negedge clk);
    chk("post_reset_addr", {{(32-AW){1'b0}}, addr}, 32'd0);
    chk("post_reset_din", {16'd0, din}, 32'h0000BEEF);
    chk("post_reset_en", {31'd0, en}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
